// File: rtl/argmax_classifier_pkg.sv
// Shared types and defaults for the argmax classifier.
// Optional feature macro: ARGMAX_MAXVAL_EN (result entries also carry the winning activation).
package argmax_pkg;

    localparam int M_DEF     = 8;
    localparam int T_DEF     = 16;
    localparam int DEPTH_DEF = 2;
    localparam int IW_DEF    = $clog2(M_DEF);

    typedef logic signed [T_DEF-1:0] act_t;

    typedef struct packed {
        logic [IW_DEF-1:0] idx;
`ifdef ARGMAX_MAXVAL_EN
        act_t              val;
`endif
    } result_t;

    // ACCUM: collecting elements 0..M-2; COMMIT: the final element is due, and
    // accepting it writes the result into the output FIFO in the same cycle.
    typedef enum logic {ACCUM, COMMIT} scan_state_t;

endpackage

// File: rtl/argmax_classifier_if.sv
// Stream interface between the final FC layer, the classifier and the result consumer.
// Optional feature macro: ARGMAX_MAXVAL_EN (adds max_out).
interface argmax_classifier_if
    import argmax_pkg::*;
#(
    parameter int M = M_DEF,
    parameter int T = T_DEF
);
    localparam int IW = $clog2(M);

    logic                 s_valid;
    logic                 s_ready;
    logic signed [T-1:0]  data_in;
    logic                 m_valid;
    logic                 m_ready;
    logic [IW-1:0]        class_out;
`ifdef ARGMAX_MAXVAL_EN
    logic signed [T-1:0]  max_out;
`endif

`ifdef ARGMAX_MAXVAL_EN
    modport slave  (input s_valid, data_in, m_ready, output s_ready, m_valid, class_out, max_out);
    modport master (output s_valid, data_in, m_ready, input s_ready, m_valid, class_out, max_out);
`else
    modport slave  (input s_valid, data_in, m_ready, output s_ready, m_valid, class_out);
    modport master (output s_valid, data_in, m_ready, input s_ready, m_valid, class_out);
`endif

endinterface

// File: rtl/argmax_classifier_result_fifo.sv
// Small synchronous result FIFO holding finished classifications until the consumer takes them.
// Push into an empty FIFO shows up at the head on the following cycle (no bypass).
module argmax_result_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [CW-1:0] count;
    logic          do_push;
    logic          do_pop;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // Guard the raw requests so a misbehaving neighbour can never corrupt the pointers.
    always_comb begin
        do_push = push && !full;
        do_pop  = pop && !empty;
        full    = (count == CW'(DEPTH));
        empty   = (count == '0);
        dout    = mem[rd_ptr];
    end

    // Storage, pointers and occupancy; simultaneous push and pop leave count unchanged.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= next_ptr(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= next_ptr(rd_ptr);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/argmax_classifier.sv
// Argmax classifier: scans M signed activations per vector and queues the winning index.
// Ties resolve to the lowest index. Optional feature macro: ARGMAX_MAXVAL_EN
// (the winning activation is queued alongside the index and driven on max_out).
module argmax_classifier
    import argmax_pkg::*;
#(
    parameter int M     = M_DEF,
    parameter int T     = T_DEF,
    parameter int DEPTH = DEPTH_DEF
) (
    input logic                clk,
    input logic                reset,
    argmax_classifier_if.slave bus
);
    localparam int IW = $clog2(M);
`ifdef ARGMAX_MAXVAL_EN
    localparam int W = IW + T;
`else
    localparam int W = IW;
`endif
    localparam logic [IW-1:0] LAST_IDX = IW'(M - 1);

    scan_state_t          state_q;
    scan_state_t          state_d;
    logic [IW-1:0]        idx_q;
    logic signed [T-1:0]  best_val_q;
    logic [IW-1:0]        best_idx_q;

    logic                 s_ready;
    logic                 accept;
    logic                 push;
    logic                 pop;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic                 data_wins;
    logic [IW-1:0]        win_idx;
    logic [W-1:0]         push_data;
    logic [W-1:0]         head_data;

    // Scan state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ACCUM;
        end else begin
            state_q <= state_d;
        end
    end

    // Enter COMMIT once element M-2 is taken; leave it when the final element is taken.
    always_comb begin
        state_d = state_q;
        if (accept) begin
            case (state_q)
                ACCUM:   if (idx_q == IW'(M - 2)) state_d = COMMIT;
                COMMIT:  state_d = ACCUM;
                default: state_d = ACCUM;
            endcase
        end
    end

    // Handshake outputs: only the final element of a vector waits for FIFO space.
    always_comb begin
        s_ready = !((state_q == COMMIT) && fifo_full);
        accept  = bus.s_valid && s_ready;
        push    = accept && (state_q == COMMIT);
        pop     = !fifo_empty && bus.m_ready;
    end

    // Final compare folds the live input in so the result is queued on the last accept.
    always_comb begin
        data_wins = (bus.data_in > best_val_q);
        win_idx   = data_wins ? idx_q : best_idx_q;
`ifdef ARGMAX_MAXVAL_EN
        push_data = {win_idx, (data_wins ? bus.data_in : best_val_q)};
`else
        push_data = win_idx;
`endif
    end

    // Running best and element counter; element 0 always seeds the running best.
    always_ff @(posedge clk) begin
        if (reset) begin
            idx_q      <= '0;
            best_val_q <= '0;
            best_idx_q <= '0;
        end else if (accept) begin
            if (idx_q == '0) begin
                best_val_q <= bus.data_in;
                best_idx_q <= '0;
            end else if (data_wins) begin
                best_val_q <= bus.data_in;
                best_idx_q <= idx_q;
            end
            idx_q <= (idx_q == LAST_IDX) ? '0 : idx_q + IW'(1);
        end
    end

    argmax_result_fifo #(
        .W     (W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .din   (push_data),
        .pop   (pop),
        .dout  (head_data),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Drive the stream interface from the handshake logic and the FIFO head.
    always_comb begin
        bus.s_ready   = s_ready;
        bus.m_valid   = !fifo_empty;
        bus.class_out = head_data[W-1 -: IW];
`ifdef ARGMAX_MAXVAL_EN
        bus.max_out   = head_data[T-1:0];
`endif
    end

endmodule

// File: tb/tb_argmax_classifier.sv
// Self-checking bench for argmax_classifier: directed vectors plus randomized traffic
// compared against a queue-based reference model. Honors ARGMAX_MAXVAL_EN if defined.
module tb_argmax_classifier;
    import argmax_pkg::*;

    localparam int M     = M_DEF;
    localparam int T     = T_DEF;
    localparam int DEPTH = DEPTH_DEF;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    argmax_classifier_if #(.M(M), .T(T)) bus ();

    argmax_classifier #(.M(M), .T(T), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int tests_run    = 0;
    int tests_failed = 0;
    int vec_done     = 0;

    int cur_vec[$];
    int exp_class[$];
    int exp_max[$];
    int pop_class[$];
    int pop_max[$];

    // Count one comparison and report it if the observed value differs.
    task automatic checkOutput(input string tag, input logic signed [31:0] actual,
                               input logic signed [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
        end
    endtask

    // Reference: the largest value, then the first position holding it.
    function automatic int ref_max(input int v[$]);
        int mx = v[0];
        foreach (v[i]) if (v[i] > mx) mx = v[i];
        return mx;
    endfunction

    function automatic int ref_class(input int v[$]);
        int mx = ref_max(v);
        foreach (v[i]) if (v[i] == mx) return i;
        return -1;
    endfunction

    // One clock cycle: drive, observe handshakes mid-cycle, advance the model, check state.
    task automatic cycle(input logic sv, input int d, input logic mr, output logic acc);
        logic signed [T-1:0] dv;
        logic                pop;
        dv          = d[T-1:0];
        bus.s_valid = sv;
        bus.data_in = dv;
        bus.m_ready = mr;
        @(negedge clk);
        acc = bus.s_valid && bus.s_ready;
        pop = bus.m_valid && bus.m_ready;
        if (pop) begin
            if (exp_class.size() == 0) begin
                checkOutput("underflow", bus.m_valid, 0);
            end else begin
                checkOutput("pop_class", bus.class_out, exp_class[0]);
`ifdef ARGMAX_MAXVAL_EN
                checkOutput("pop_max", bus.max_out, exp_max[0]);
                pop_max.push_back(int'(bus.max_out));
`endif
            end
            pop_class.push_back(int'(bus.class_out));
        end
        @(posedge clk);
        #1;
        if (pop && exp_class.size() > 0) begin
            void'(exp_class.pop_front());
            void'(exp_max.pop_front());
        end
        if (acc) begin
            cur_vec.push_back(int'(dv));
            if (cur_vec.size() == M) begin
                exp_class.push_back(ref_class(cur_vec));
                exp_max.push_back(ref_max(cur_vec));
                cur_vec.delete();
                vec_done++;
                checkOutput("overflow", exp_class.size() <= DEPTH, 1);
            end
        end
        checkOutput("m_valid", bus.m_valid, exp_class.size() != 0);
        checkOutput("s_ready", bus.s_ready, !(cur_vec.size() == M - 1 && exp_class.size() == DEPTH));
        if (exp_class.size() != 0) begin
            checkOutput("head_class", bus.class_out, exp_class[0]);
`ifdef ARGMAX_MAXVAL_EN
            checkOutput("head_max", bus.max_out, exp_max[0]);
`endif
        end
    endtask

    // Feed elements first..last of a vector, each with a bounded wait for acceptance.
    task automatic applyStimulus(input int v[M], input int first, input int last, input logic mr);
        logic acc;
        int   tries;
        for (int i = first; i <= last; i++) begin
            tries = 0;
            acc   = 1'b0;
            while (!acc && tries < 50) begin
                cycle(1'b1, v[i], mr, acc);
                tries++;
            end
            if (!acc) checkOutput("accept_timeout", acc, 1);
        end
    endtask

    // Pop everything queued, bounded by a cycle budget.
    task automatic drain();
        logic acc;
        int   tries = 0;
        while ((exp_class.size() != 0 || bus.m_valid) && tries < 100) begin
            cycle(1'b0, 0, 1'b1, acc);
            tries++;
        end
        checkOutput("drain_empty", bus.m_valid, 0);
    endtask

    // Synchronous reset for one edge; model is cleared and reset values are checked.
    task automatic do_reset();
        reset       = 1'b1;
        bus.s_valid = 1'b0;
        bus.m_ready = 1'b0;
        bus.data_in = '0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        cur_vec.delete();
        exp_class.delete();
        exp_max.delete();
        checkOutput("rst_m_valid", bus.m_valid, 0);
        checkOutput("rst_s_ready", bus.s_ready, 1);
        checkOutput("rst_class", bus.class_out, 0);
`ifdef ARGMAX_MAXVAL_EN
        checkOutput("rst_max", bus.max_out, 0);
`endif
    endtask

    initial begin
        int   va[M];
        int   vb[M];
        int   vc[M];
        logic acc;
        logic sv;
        logic mr;
        int   d;
        int   mr_pct;
        int   cyc;
        logic signed [T-1:0] rt;

        bus.s_valid = 1'b0;
        bus.m_ready = 1'b0;
        bus.data_in = '0;
        @(posedge clk);
        do_reset();

        // Single mixed-sign vector: winner at index 1, result visible right after last accept.
        pop_class.delete(); pop_max.delete();
        va = '{-119, 123, -114, 71, 17, 113, 39, -113};
        applyStimulus(va, 0, M - 1, 1'b1);
        checkOutput("t1_latency", bus.m_valid, 1);
        drain();
        checkOutput("t1_count", pop_class.size(), 1);
        if (pop_class.size() > 0) checkOutput("t1_class", pop_class[0], 1);
`ifdef ARGMAX_MAXVAL_EN
        if (pop_max.size() > 0) checkOutput("t1_max", pop_max[0], 123);
`endif

        // Ties go to the lowest index.
        pop_class.delete(); pop_max.delete();
        va = '{5, 9, 9, 0, 0, 0, 0, 9};
        applyStimulus(va, 0, M - 1, 1'b1);
        drain();
        if (pop_class.size() > 0) checkOutput("t2_class", pop_class[0], 1);
        else checkOutput("t2_count", pop_class.size(), 1);

        // All-negative vector.
        pop_class.delete(); pop_max.delete();
        va = '{-3, -1, -7, -2, -9, -4, -5, -6};
        applyStimulus(va, 0, M - 1, 1'b1);
        drain();
        if (pop_class.size() > 0) checkOutput("t3_class", pop_class[0], 1);
        else checkOutput("t3_count", pop_class.size(), 1);
`ifdef ARGMAX_MAXVAL_EN
        if (pop_max.size() > 0) checkOutput("t3_max", pop_max[0], -1);
`endif

        // Back-pressure: two results fill the FIFO, third vector stalls on its last element.
        pop_class.delete(); pop_max.delete();
        va = '{1, 2, 3, 4, 5, 6, 7, 100};
        vb = '{90, 1, 2, 3, -4, 5, 6, 7};
        vc = '{-5, 0, 3, 2, 77, -1, 10, 20};
        applyStimulus(va, 0, M - 1, 1'b0);
        applyStimulus(vb, 0, M - 1, 1'b0);
        applyStimulus(vc, 0, M - 2, 1'b0);
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, vc[M-1], 1'b0, acc);
            checkOutput("t4_stall_acc", acc, 0);
            checkOutput("t4_stall_ready", bus.s_ready, 0);
        end
        applyStimulus(vc, M - 1, M - 1, 1'b1);
        drain();
        checkOutput("t4_count", pop_class.size(), 3);
        if (pop_class.size() == 3) begin
            checkOutput("t4_first", pop_class[0], 7);
            checkOutput("t4_second", pop_class[1], 0);
            checkOutput("t4_third", pop_class[2], 4);
        end
        checkOutput("t4_ready_back", bus.s_ready, 1);

        // Reset mid-vector with a result queued: both must be discarded.
        pop_class.delete(); pop_max.delete();
        applyStimulus(va, 0, M - 1, 1'b0);
        applyStimulus(vb, 0, 3, 1'b0);
        do_reset();
        vc = '{0, 0, 0, 0, 0, 0, 50, 0};
        applyStimulus(vc, 0, M - 1, 1'b1);
        drain();
        checkOutput("t5_count", pop_class.size(), 1);
        if (pop_class.size() > 0) checkOutput("t5_class", pop_class[0], 6);

        // Randomized traffic with varying consumer back-pressure.
        vec_done = 0;
        mr_pct   = 50;
        cyc      = 0;
        while (vec_done < 1000 && cyc < 60000) begin
            if (cyc % 50 == 0) begin
                case ($urandom_range(0, 2))
                    0:       mr_pct = 10;
                    1:       mr_pct = 50;
                    default: mr_pct = 90;
                endcase
            end
            sv = ($urandom_range(0, 3) != 0);
            mr = (int'($urandom_range(0, 99)) < mr_pct);
            if ($urandom_range(0, 1) == 0) begin
                d = int'($urandom_range(0, 8)) - 4;
            end else begin
                rt = T'($urandom);
                d  = int'(rt);
            end
            cycle(sv, d, mr, acc);
            cyc++;
        end
        checkOutput("rand_vectors", vec_done >= 1000, 1);
        drain();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
